intdiv_sd2_conv: RTL
====================

Name: intdiv_sd2_conv

Overview:
- Sequential on-the-fly converter. Accepts W signed-digit radix-2 (SD2) quotient digits, MSB first, from the divider iteration stage.
- Produces the equivalent (W+1)-bit two's complement quotient plus sign and zero flags.
- Sits between the SD2 digit-selection/sign logic and the divider result register. It is the decode direction of the SD2 digit stream.

Parameters:
- W, 8, number of SD2 digits per quotient (W >= 2); result width is W+1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new conversion; clears internal state
- digit_valid  in  1  digit holds a valid quotient digit
- digit  in  2  SD2 digit, (p,n) encoding: bit1 = p, bit0 = n, value = p - n (10 = +1, 01 = -1, 00 = 0, 11 = 0)
- digit_ready  out  1  converter accepts a digit this cycle
- q  out  W+1  two's complement quotient, valid while q_valid
- q_neg  out  1  quotient negative (equals q[W])
- q_zero  out  1  quotient equals zero
- q_valid  out  1  result available
- q_ready  in  1  consumer takes result
- busy  out  1  conversion in progress (state CONV)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; Q = 0; QM = all ones; cnt = 0; digit_ready = 0; q_valid = 0; busy = 0; q = 0; q_neg = 0; q_zero = 0.
- Internal registers: Q (W+1 bits), QM = Q - 1 (W+1 bits), digit counter cnt (clog2(W)+1 bits).
- FSM states: IDLE, CONV, DONE.
- IDLE: digit_ready = 0. On start: Q <= 0, QM <= all ones, cnt <= 0, go to CONV.
- CONV: digit_ready = 1, busy = 1. A digit is accepted when digit_valid & digit_ready. Update rules (shift left, append):
  - d = +1: Q <= {Q[W-1:0],1}, QM <= {Q[W-1:0],0}
  - d = 0 (00 or 11): Q <= {Q[W-1:0],0}, QM <= {QM[W-1:0],1}
  - d = -1: Q <= {QM[W-1:0],1}, QM <= {QM[W-1:0],0}
  - cnt increments per accepted digit.
  - On acceptance of digit number W (cnt == W-1): go to DONE; q_valid rises the next cycle.
  - Cycles with digit_valid low: no state change.
- Latency: q_valid asserted 1 cycle after the last digit is accepted. Minimum W+1 cycles from start to q_valid.
- DONE: q_valid = 1; q = Q; q_neg = Q[W]; q_zero = (Q == 0). Outputs are registered and stable while q_valid is held. On q_ready: q_valid deasserts next cycle, go to IDLE.
- Arithmetic: W digits span ±(2^W - 1), so W+1 bits never overflow. Q and QM only drop their top bit on shift; the initial all-ones QM sign-extends correctly.
- Simultaneous events:
  - start in CONV or DONE aborts the current operation: state reinitialised as in IDLE, q_valid drops next cycle, any digit presented in that cycle is discarded.
  - start together with q_ready in DONE: start wins.
- digit_valid in IDLE or DONE is ignored; digit_ready = 0 there.
- Reset asserted mid-conversion: immediate return to reset values; no partial result is ever flagged valid.

Test Plan:
- W=4, start, digits 10,00,01,10 (+1,0,-1,+1) -> q = 5'b00111 (7), q_neg = 0, q_zero = 0, q_valid 1 cycle after 4th digit.
- W=4, digits 01,01,01,01 -> q = 5'b10001 (-15), q_neg = 1; then digits 10,01,01,01 -> q = 5'b00001 (+1), q_neg = 0.
- W=4, digits 00,11,00,11 (both zero encodings) -> q = 0, q_zero = 1, q_neg = 0.
- W=4, digit_valid toggled 1-0-0-1-1-0-1 presenting +1,+1,+1,+1 -> only valid cycles consumed; q = 5'b01111 (15). Hold q_ready low 5 cycles -> q and q_valid stable; q_ready pulse -> q_valid low next cycle, state IDLE.
- Deassert rst_n after 2 digits -> all outputs 0 immediately. Release rst_n and start a fresh 4-digit run of -1,0,0,0 -> q = 5'b11000 (-8).
- Assert start after 3 digits of a run -> restart. Next 4 digits +1,0,0,0 -> q = 5'b01000 (8). No q_valid pulse from the aborted run.

Source files
------------

// File: rtl/intdiv_sd2_conv.sv
// On-the-fly converter from an MSB-first SD2 quotient digit stream to a (W+1)-bit
// two's complement quotient, keeping Q and Q-1 so each digit is a pure shift-append.
module intdiv_sd2_conv #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [1:0]   digit,
    output logic         digit_ready,
    output logic [W:0]   q,
    output logic         q_neg,
    output logic         q_zero,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         busy
);

    localparam int unsigned CW = $clog2(W) + 1;

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e        state_q, state_d;
    logic [W:0]    acc_q, acc_d;
    logic [W:0]    accm_q, accm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W:0]    q_q, q_d;
    logic          q_neg_q, q_neg_d;
    logic          q_zero_q, q_zero_d;
    logic          q_valid_q, q_valid_d;

    logic          accept;
    logic          d_pos;
    logic          d_neg;
    logic [W:0]    acc_upd;
    logic [W:0]    accm_upd;

    assign d_pos  = (digit == 2'b10);
    assign d_neg  = (digit == 2'b01);
    assign accept = (state_q == StConv) && digit_valid;

    // Both encodings of zero (00 and 11) fall through to the zero-digit update.
    always_comb begin
        acc_upd  = {acc_q[W-1:0], 1'b0};
        accm_upd = {accm_q[W-1:0], 1'b1};
        if (d_pos) begin
            acc_upd  = {acc_q[W-1:0], 1'b1};
            accm_upd = {acc_q[W-1:0], 1'b0};
        end else if (d_neg) begin
            acc_upd  = {accm_q[W-1:0], 1'b1};
            accm_upd = {accm_q[W-1:0], 1'b0};
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        accm_d    = accm_q;
        cnt_d     = cnt_q;
        q_d       = q_q;
        q_neg_d   = q_neg_q;
        q_zero_d  = q_zero_q;
        q_valid_d = q_valid_q;

        if (start) begin
            // Start wins over any digit or q_ready in the same cycle.
            state_d   = StConv;
            acc_d     = '0;
            accm_d    = '1;
            cnt_d     = '0;
            q_d       = '0;
            q_neg_d   = 1'b0;
            q_zero_d  = 1'b0;
            q_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StConv: begin
                    if (accept) begin
                        acc_d  = acc_upd;
                        accm_d = accm_upd;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == CW'(W - 1)) begin
                            state_d   = StDone;
                            q_d       = acc_upd;
                            q_neg_d   = acc_upd[W];
                            q_zero_d  = (acc_upd == '0);
                            q_valid_d = 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (q_ready) begin
                        state_d   = StIdle;
                        q_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    q_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            accm_q    <= '1;
            cnt_q     <= '0;
            q_q       <= '0;
            q_neg_q   <= 1'b0;
            q_zero_q  <= 1'b0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            accm_q    <= accm_d;
            cnt_q     <= cnt_d;
            q_q       <= q_d;
            q_neg_q   <= q_neg_d;
            q_zero_q  <= q_zero_d;
            q_valid_q <= q_valid_d;
        end
    end

    assign digit_ready = (state_q == StConv);
    assign busy        = (state_q == StConv);
    assign q           = q_q;
    assign q_neg       = q_neg_q;
    assign q_zero      = q_zero_q;
    assign q_valid     = q_valid_q;

endmodule
